key_window_scheduler: RTL and testbench
=======================================

Name: key_window_scheduler

Overview:
- Sequencer that feeds time-windowed unlock keys to a counter-locked behavioural FSM (Cute-Lock style) and owns that FSM's reset.
- Accepts NUM_KEYS keys over a valid/ready config port and holds the locked FSM in reset until all keys are loaded.
- Then releases the locked FSM's reset and runs a mirror of its window counter, so the key presented always matches the FSM's current window.
- Sits between the key-provisioning host and the keyinput bus of the locked FSM.

Parameters:
KEY_W, 12, width of each key / keyinput bus
NUM_KEYS, 4, number of key windows per period
WIN_LEN, 9, counter values per window
CNT_W, 7, mirror counter width; must satisfy 2^CNT_W > NUM_KEYS*WIN_LEN (PERIOD, derived, 36 by default)

Ports:
clk  in  1  clock; all state updates on falling edge, matching the locked FSM
rst  in  1  asynchronous, active-high reset
cfg_valid  in  1  key beat valid
cfg_ready  out  1  key beat accepted when valid&&ready at a falling edge
cfg_data  in  KEY_W  key value; beat k goes to slot k
cfg_clear  in  1  zeroize keys, return to IDLE
key_out  out  KEY_W  drives the locked FSM keyinput bus
tgt_rst  out  1  registered reset to the locked FSM, active-high
loaded  out  1  all NUM_KEYS slots written
win_idx  out  log2(NUM_KEYS)  current window index
cnt_mirror  out  CNT_W  mirror of the locked FSM counter
cfg_err  out  1  one-cycle pulse: beat offered while ARMED/RUN

Behaviour:
- Reset (async, immediate): state=IDLE; slots=0; beat index=0; cnt_mirror=0; win_idx=0; tgt_rst=1; loaded=0; cfg_err=0; key_out=0; cfg_ready=1.
- States: IDLE, LOAD, ARMED, RUN. cfg_ready=1 in IDLE/LOAD only.
- IDLE: an accepted beat writes slot 0 -> LOAD (or directly -> ARMED when NUM_KEYS=1).
- LOAD: each accepted beat writes slot[index] and increments index. The beat that writes slot NUM_KEYS-1 moves the block to ARMED and sets loaded=1. Cycles without cfg_valid hold state.
- ARMED: lasts exactly one edge. tgt_rst is still 1. Next edge -> RUN and clears tgt_rst.
- RUN: tgt_rst=0. cnt_mirror increments on every falling edge where the state was already RUN before the edge. The first increment is therefore the edge after tgt_rst falls; this is identical to the locked FSM counter's first increment.
- Wrap: cnt_mirror = PERIOD-1 -> 0. win_idx increments when cnt_mirror goes from k*WIN_LEN-1 to k*WIN_LEN, and returns to 0 on wrap.
- Invariant in RUN: cnt_mirror equals the locked FSM counter, and win_idx = cnt_mirror / WIN_LEN.
- key_out = slot[win_idx] in ARMED/RUN and 0 in IDLE/LOAD. key_out is a mux of registered state only, with no input-to-output combinational path.
- cfg_valid in ARMED/RUN: beat ignored, slots unchanged, cfg_err pulses high for one cycle after that edge.
- cfg_clear (priority over any beat, any state): next edge -> IDLE; slots=0; index=0; cnt_mirror=0; win_idx=0; loaded=0; tgt_rst=1.
- cfg_clear together with cfg_valid: the beat is dropped and cfg_err stays 0.
- rst asserted mid-RUN: all outputs return to reset values immediately, including tgt_rst=1. Keys must be reloaded.
- Slot contents are only readable through key_out. No readback port exists.

Test Plan:
- Load 0x981, 0xAE9, 0x892, 0x455 with back-to-back beats -> loaded=1 after 4th accepted beat; ARMED for 1 edge; tgt_rst falls at next edge.
- Continue in RUN -> key_out=0x981 for cnt 0..8, 0xAE9 for 9..17, 0x892 for 18..26, 0x455 for 27..35; at cnt 35->0 win_idx=0 and key_out=0x981. Check against a locked FSM instance reaching no decoy state over 3 periods.
- Load with cfg_valid gaps (valid low 3 cycles between beats) -> same slot contents; tgt_rst stays 1 until ARMED exits.
- cfg_valid with data 0xFFF during RUN at cnt 20 -> cfg_err one-cycle pulse, key_out stays 0x892, counting undisturbed.
- cfg_clear at cnt 30 with cfg_valid high -> next edge: IDLE, key_out=0, tgt_rst=1, cnt_mirror=0, loaded=0, cfg_err=0.
- Assert rst mid-LOAD after 2 beats, then reload all 4 -> slots 0/1 were zeroed and overwritten; behaviour identical to the first scenario.

Source files
------------

// File: rtl/key_window_scheduler.sv
// key_window_scheduler
//
// Loads NUM_KEYS unlock keys over a valid/ready config port, then presents
// them one window at a time to a counter-locked behavioural FSM. The block
// owns that FSM's reset: it holds the FSM in reset while keys are loading,
// releases it one edge after the last key arrives, and then runs a mirror
// of the FSM's window counter so key_out always matches the FSM's window.
//
// All state updates happen on the falling edge of clk, matching the locked FSM.
//
// Handshake: a key beat transfers on a falling edge where cfg_valid and
// cfg_ready are both high and cfg_clear is low. cfg_ready depends only on
// registered state. cfg_data may change freely while cfg_valid is low.
// Beat k is written to slot k.
//
// Ports:
//   clk        clock (falling-edge active)
//   rst        asynchronous active-high reset
//   cfg_valid  key beat valid
//   cfg_ready  key beat can be accepted (IDLE/LOAD only)
//   cfg_data   key value
//   cfg_clear  zeroize keys and counters, return to IDLE (beats the handshake)
//   key_out    keyinput bus of the locked FSM (slot[win_idx] in ARMED/RUN)
//   tgt_rst    registered active-high reset to the locked FSM
//   loaded     all NUM_KEYS slots written
//   win_idx    current key window index
//   cnt_mirror mirror of the locked FSM counter
//   cfg_err    one-cycle pulse: beat offered while ARMED/RUN
//   state_dbg  current FSM state (0 IDLE, 1 LOAD, 2 ARMED, 3 RUN)

module key_window_scheduler #(
   parameter int KEY_W    = 12,
   parameter int NUM_KEYS = 4,
   parameter int WIN_LEN  = 9,
   parameter int CNT_W    = 7,
   localparam int IDX_W   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [KEY_W-1:0] cfg_data,
   input  logic             cfg_clear,
   output logic [KEY_W-1:0] key_out,
   output logic             tgt_rst,
   output logic             loaded,
   output logic [IDX_W-1:0] win_idx,
   output logic [CNT_W-1:0] cnt_mirror,
   output logic             cfg_err,
   output logic [1:0]       state_dbg
);

   localparam int PERIOD = NUM_KEYS * WIN_LEN;
   localparam int POS_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_ARMED = 2'd2,
      S_RUN   = 2'd3
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [KEY_W-1:0] slots [NUM_KEYS];
   logic [IDX_W-1:0] beat_idx;
   // Position inside the current window; avoids a divider for win_idx.
   logic [POS_W-1:0] win_pos;
   logic             accept;
   logic             last_beat;
   logic             busy;

   assign busy      = (state == S_ARMED) || (state == S_RUN);
   assign accept    = cfg_valid && !busy && !cfg_clear;
   assign last_beat = (beat_idx == IDX_W'(NUM_KEYS - 1));

   // State register
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      if (cfg_clear) begin
         state_next = S_IDLE;
      end else begin
         case (state)
            S_IDLE, S_LOAD: begin
               if (accept) begin
                  state_next = last_beat ? S_ARMED : S_LOAD;
               end
            end
            S_ARMED: state_next = S_RUN;
            S_RUN:   state_next = S_RUN;
            default: state_next = S_IDLE;
         endcase
      end
   end

   // Outputs: muxes of registered state only, no path from cfg_* inputs.
   always_comb begin
      cfg_ready = !busy;
      key_out   = '0;
      if (busy) begin
         key_out = slots[win_idx];
      end
      state_dbg = state;
   end

   // Key slots, beat index, mirror counter and registered flags
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_KEYS; i++) begin
            slots[i] <= '0;
         end
         beat_idx   <= '0;
         cnt_mirror <= '0;
         win_pos    <= '0;
         win_idx    <= '0;
         loaded     <= 1'b0;
         cfg_err    <= 1'b0;
         tgt_rst    <= 1'b1;
      end else begin
         // A clear drops any simultaneous beat without flagging it.
         cfg_err <= cfg_valid && busy && !cfg_clear;
         // Released exactly on the ARMED -> RUN edge; the locked FSM sees the
         // old value at that edge, so both counters first step one edge later.
         tgt_rst <= (state_next != S_RUN);

         if (cfg_clear) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
               slots[i] <= '0;
            end
            beat_idx   <= '0;
            cnt_mirror <= '0;
            win_pos    <= '0;
            win_idx    <= '0;
            loaded     <= 1'b0;
         end else begin
            if (accept) begin
               slots[beat_idx] <= cfg_data;
               if (last_beat) begin
                  beat_idx <= '0;
                  loaded   <= 1'b1;
               end else begin
                  beat_idx <= beat_idx + 1'b1;
               end
            end

            if (state == S_RUN) begin
               if (cnt_mirror == CNT_W'(PERIOD - 1)) begin
                  cnt_mirror <= '0;
                  win_pos    <= '0;
                  win_idx    <= '0;
               end else begin
                  cnt_mirror <= cnt_mirror + 1'b1;
                  if (win_pos == POS_W'(WIN_LEN - 1)) begin
                     win_pos <= '0;
                     win_idx <= win_idx + 1'b1;
                  end else begin
                     win_pos <= win_pos + 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_key_window_scheduler.sv
// Testbench for key_window_scheduler: table-driven load sequences plus
// hand-written corner sequences, checked against hand-computed values and a
// behavioural counter-locked FSM driven by key_out / tgt_rst.

module tb_key_window_scheduler;

   localparam int KEY_W = 12;
   localparam int CNT_W = 7;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_ARMED = 2'd2;
   localparam logic [1:0] ST_RUN   = 2'd3;

   // ---------------- clock / reset ----------------
   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic [KEY_W-1:0] cfg_data = '0;
   logic             cfg_clear = 1'b0;
   logic [KEY_W-1:0] key_out;
   logic             tgt_rst;
   logic             loaded;
   logic [1:0]       win_idx;
   logic [CNT_W-1:0] cnt_mirror;
   logic             cfg_err;
   logic [1:0]       state_dbg;

   always #5 clk = ~clk;

   key_window_scheduler #(
      .KEY_W(KEY_W), .NUM_KEYS(4), .WIN_LEN(9), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
      .cfg_clear(cfg_clear), .key_out(key_out), .tgt_rst(tgt_rst),
      .loaded(loaded), .win_idx(win_idx), .cnt_mirror(cnt_mirror),
      .cfg_err(cfg_err), .state_dbg(state_dbg)
   );

   // ---------------- locked FSM model ----------------
   // Counter advances on falling edges while out of reset; any edge where the
   // presented key does not match the counter's window sends it to a decoy.
   logic [KEY_W-1:0] good_keys [4];
   int               lk_cnt;
   logic             lk_decoy;

   initial begin
      good_keys[0] = 12'h981;
      good_keys[1] = 12'hAE9;
      good_keys[2] = 12'h892;
      good_keys[3] = 12'h455;
   end

   always @(negedge clk or posedge tgt_rst) begin
      if (tgt_rst) begin
         lk_cnt   <= 0;
         lk_decoy <= 1'b0;
      end else begin
         if (key_out !== good_keys[lk_cnt / 9]) lk_decoy <= 1'b1;
         lk_cnt <= (lk_cnt == 35) ? 0 : lk_cnt + 1;
      end
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   int exp_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic             v;
      logic             clr;
      logic [KEY_W-1:0] d;
      logic [1:0]       st;
      logic             rdy;
      logic             ld;
      logic             trst;
      logic [KEY_W-1:0] key;
      logic [CNT_W-1:0] cnt;
      logic [1:0]       win;
      logic             err;
   } vec_t;

   function automatic vec_t mk(input logic v, input logic clr, input logic [KEY_W-1:0] d,
                               input logic [1:0] st, input logic rdy, input logic ld,
                               input logic trst, input logic [KEY_W-1:0] key,
                               input logic [CNT_W-1:0] cnt, input logic [1:0] win,
                               input logic err);
      vec_t r;
      r.v = v; r.clr = clr; r.d = d; r.st = st; r.rdy = rdy; r.ld = ld;
      r.trst = trst; r.key = key; r.cnt = cnt; r.win = win; r.err = err;
      return r;
   endfunction

   // ---------------- driver tasks ----------------
   // Drive inputs away from the falling edge, let one falling edge pass,
   // then sample 1 time unit after it.
   task automatic step(input logic v, input logic clr, input logic [KEY_W-1:0] d);
      cfg_valid = v;
      cfg_clear = clr;
      cfg_data  = d;
      @(negedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input vec_t t);
      chk({tag, ".state"},   32'(state_dbg),  32'(t.st));
      chk({tag, ".ready"},   32'(cfg_ready),  32'(t.rdy));
      chk({tag, ".loaded"},  32'(loaded),     32'(t.ld));
      chk({tag, ".tgt_rst"}, 32'(tgt_rst),    32'(t.trst));
      chk({tag, ".key"},     32'(key_out),    32'(t.key));
      chk({tag, ".cnt"},     32'(cnt_mirror), 32'(t.cnt));
      chk({tag, ".win"},     32'(win_idx),    32'(t.win));
      chk({tag, ".err"},     32'(cfg_err),    32'(t.err));
   endtask

   task automatic apply_vec(input string tag, input vec_t t);
      step(t.v, t.clr, t.d);
      check_all(tag, t);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, ".state"},   32'(state_dbg),  32'(ST_IDLE));
      chk({tag, ".ready"},   32'(cfg_ready),  32'd1);
      chk({tag, ".loaded"},  32'(loaded),     32'd0);
      chk({tag, ".tgt_rst"}, 32'(tgt_rst),    32'd1);
      chk({tag, ".key"},     32'(key_out),    32'd0);
      chk({tag, ".cnt"},     32'(cnt_mirror), 32'd0);
      chk({tag, ".win"},     32'(win_idx),    32'd0);
      chk({tag, ".err"},     32'(cfg_err),    32'd0);
   endtask

   // Idle cycles in RUN; exp_cnt carries the expected counter between calls.
   task automatic run_cycles(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'b0, '0);
         exp_cnt = (exp_cnt + 1) % 36;
         chk({tag, ".cnt"},     32'(cnt_mirror), 32'(exp_cnt));
         chk({tag, ".win"},     32'(win_idx),    32'(exp_cnt / 9));
         chk({tag, ".key"},     32'(key_out),    32'(good_keys[exp_cnt / 9]));
         chk({tag, ".tgt_rst"}, 32'(tgt_rst),    32'd0);
         chk({tag, ".lk_cnt"},  32'(cnt_mirror), 32'(lk_cnt));
         chk({tag, ".decoy"},   32'(lk_decoy),   32'd0);
      end
   endtask

   // ---------------- vector tables ----------------
   vec_t load_tbl [6];
   vec_t gap_tbl [16];

   initial begin
      // Back-to-back load, then ARMED for one edge, then RUN.
      load_tbl[0] = mk(1, 0, 12'h981, ST_LOAD,  1, 0, 1, 12'h000, 0, 0, 0);
      load_tbl[1] = mk(1, 0, 12'hAE9, ST_LOAD,  1, 0, 1, 12'h000, 0, 0, 0);
      load_tbl[2] = mk(1, 0, 12'h892, ST_LOAD,  1, 0, 1, 12'h000, 0, 0, 0);
      load_tbl[3] = mk(1, 0, 12'h455, ST_ARMED, 0, 1, 1, 12'h981, 0, 0, 0);
      load_tbl[4] = mk(0, 0, 12'h000, ST_RUN,   0, 1, 0, 12'h981, 0, 0, 0);
      load_tbl[5] = mk(0, 0, 12'h000, ST_RUN,   0, 1, 0, 12'h981, 1, 0, 0);

      // Load with 3-cycle valid gaps; a beat offered in ARMED is flagged
      // and must not overwrite slot 0.
      gap_tbl[0]  = mk(1, 0, 12'h981, ST_LOAD,  1, 0, 1, 12'h000, 0, 0, 0);
      gap_tbl[1]  = mk(0, 0, 12'h111, ST_LOAD,  1, 0, 1, 12'h000, 0, 0, 0);
      gap_tbl[2]  = mk(0, 0, 12'h222, ST_LOAD,  1, 0, 1, 12'h000, 0, 0, 0);
      gap_tbl[3]  = mk(0, 0, 12'h333, ST_LOAD,  1, 0, 1, 12'h000, 0, 0, 0);
      gap_tbl[4]  = mk(1, 0, 12'hAE9, ST_LOAD,  1, 0, 1, 12'h000, 0, 0, 0);
      gap_tbl[5]  = mk(0, 0, 12'h000, ST_LOAD,  1, 0, 1, 12'h000, 0, 0, 0);
      gap_tbl[6]  = mk(0, 0, 12'h000, ST_LOAD,  1, 0, 1, 12'h000, 0, 0, 0);
      gap_tbl[7]  = mk(0, 0, 12'h000, ST_LOAD,  1, 0, 1, 12'h000, 0, 0, 0);
      gap_tbl[8]  = mk(1, 0, 12'h892, ST_LOAD,  1, 0, 1, 12'h000, 0, 0, 0);
      gap_tbl[9]  = mk(0, 0, 12'h000, ST_LOAD,  1, 0, 1, 12'h000, 0, 0, 0);
      gap_tbl[10] = mk(0, 0, 12'h000, ST_LOAD,  1, 0, 1, 12'h000, 0, 0, 0);
      gap_tbl[11] = mk(0, 0, 12'h000, ST_LOAD,  1, 0, 1, 12'h000, 0, 0, 0);
      gap_tbl[12] = mk(1, 0, 12'h455, ST_ARMED, 0, 1, 1, 12'h981, 0, 0, 0);
      gap_tbl[13] = mk(1, 0, 12'hFFF, ST_RUN,   0, 1, 0, 12'h981, 0, 0, 1);
      gap_tbl[14] = mk(0, 0, 12'h000, ST_RUN,   0, 1, 0, 12'h981, 1, 0, 0);
      gap_tbl[15] = mk(0, 0, 12'h000, ST_RUN,   0, 1, 0, 12'h981, 2, 0, 0);
   end

   // ---------------- test sequence ----------------
   initial begin
      // Reset state
      #1 rst = 1'b1;
      #2;
      check_reset_outputs("reset");
      @(negedge clk); @(negedge clk);
      #1 rst = 1'b0;
      step(1'b0, 1'b0, '0);
      check_reset_outputs("idle_hold");

      // Scenario 1: back-to-back load, then three full periods
      for (int i = 0; i < 6; i++) apply_vec($sformatf("load[%0d]", i), load_tbl[i]);
      exp_cnt = 1;
      run_cycles("run3p", 3 * 36);

      // Clear from RUN, then gapped load
      step(1'b0, 1'b1, '0);
      check_reset_outputs("clear_run");
      for (int i = 0; i < 16; i++) apply_vec($sformatf("gap[%0d]", i), gap_tbl[i]);
      exp_cnt = 2;
      run_cycles("gap_run", 18);
      chk("at_cnt20", 32'(cnt_mirror), 32'd20);

      // Beat during RUN at cnt 20: flagged, ignored, counting undisturbed
      apply_vec("run_beat", mk(1, 0, 12'hFFF, ST_RUN, 0, 1, 0, 12'h892, 21, 2, 1));
      apply_vec("run_beat_after", mk(0, 0, 12'h000, ST_RUN, 0, 1, 0, 12'h892, 22, 2, 0));
      exp_cnt = 22;
      run_cycles("to_cnt30", 8);
      chk("at_cnt30", 32'(cnt_mirror), 32'd30);

      // Clear with a simultaneous beat: beat dropped, no error pulse
      apply_vec("clear_beat", mk(1, 1, 12'hFFF, ST_IDLE, 1, 0, 1, 12'h000, 0, 0, 0));
      apply_vec("clear_after", mk(0, 0, 12'h000, ST_IDLE, 1, 0, 1, 12'h000, 0, 0, 0));

      // Reset mid-LOAD after two stale beats, then full reload
      apply_vec("stale0", mk(1, 0, 12'h123, ST_LOAD, 1, 0, 1, 12'h000, 0, 0, 0));
      apply_vec("stale1", mk(1, 0, 12'h456, ST_LOAD, 1, 0, 1, 12'h000, 0, 0, 0));
      cfg_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check_reset_outputs("rst_load");
      @(negedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 6; i++) apply_vec($sformatf("reload[%0d]", i), load_tbl[i]);
      exp_cnt = 1;
      run_cycles("reload_run", 36 + 5);

      // Reset mid-RUN: outputs return to reset values without waiting for an edge
      #2 rst = 1'b1;
      #1;
      check_reset_outputs("rst_run");
      @(negedge clk);
      #1 rst = 1'b0;
      step(1'b0, 1'b0, '0);
      check_reset_outputs("after_rst_run");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
